// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions.
//   - Response codes OKAY/EXOKAY/SLVERR/DECERR (BRESP/RRESP encoding).
//   - axi4l_cmd_state_t: state encoding of the command-to-AXI4-Lite master.
package axi4l_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } axi4l_cmd_state_t;

endpackage

// File: rtl/axi4l_cmd_master.sv
// Single-outstanding AXI4-Lite master.
// Converts one valid/ready command into one AXI4-Lite read or write and
// returns the outcome on a valid/ready response stream. A non-responding
// slave is turned into a SLVERR response with rsp_timeout set.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command stream
//   rsp_valid/ready/rdata/resp/timeout       response stream
//   axi4l_aw*, axi4l_w*, axi4l_b*, axi4l_ar*, axi4l_r*  AXI4-Lite master side
//
// Parameter TIMEOUT: cycles from command acceptance to forced abort
// (0 disables). The AXI valid/ready of the pending channel stays up for
// exactly TIMEOUT cycles; the response appears on the following cycle.
module axi4l_cmd_master
  import axi4l_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] axi4l_awaddr,
  output logic [2:0]  axi4l_awprot,
  output logic        axi4l_awvalid,
  input  logic        axi4l_awready,
  output logic [31:0] axi4l_wdata,
  output logic [3:0]  axi4l_wstrb,
  output logic        axi4l_wvalid,
  input  logic        axi4l_wready,
  input  logic [1:0]  axi4l_bresp,
  input  logic        axi4l_bvalid,
  output logic        axi4l_bready,
  output logic [31:0] axi4l_araddr,
  output logic [2:0]  axi4l_arprot,
  output logic        axi4l_arvalid,
  input  logic        axi4l_arready,
  input  logic [31:0] axi4l_rdata,
  input  logic [1:0]  axi4l_rresp,
  input  logic        axi4l_rvalid,
  output logic        axi4l_rready
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  // Abort fires at the end of the TIMEOUT-th busy cycle (counter is 0 in
  // the first busy cycle).
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  axi4l_cmd_state_t state, state_nxt;

  logic             aw_done, w_done;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       wstrb_q;

  logic accept, busy, tmo_hit;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign axi4l_awprot = 3'b000;
  assign axi4l_arprot = 3'b000;
  assign axi4l_awaddr = addr_q;
  assign axi4l_araddr = addr_q;
  assign axi4l_wdata  = wdata_q;
  assign axi4l_wstrb  = wstrb_q;

  assign aw_hs = axi4l_awvalid && axi4l_awready;
  assign w_hs  = axi4l_wvalid  && axi4l_wready;
  assign b_hs  = axi4l_bvalid  && axi4l_bready;
  assign ar_hs = axi4l_arvalid && axi4l_arready;
  assign r_hs  = axi4l_rvalid  && axi4l_rready;

  assign accept  = cmd_valid && (state == ST_IDLE);
  assign busy    = (state == ST_WR) || (state == ST_WR_RESP) ||
                   (state == ST_RD_ADDR) || (state == ST_RD_DATA);
  assign tmo_hit = (TIMEOUT != 0) && busy && (cnt == CNT_LAST);

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    axi4l_awvalid = 1'b0;
    axi4l_wvalid  = 1'b0;
    axi4l_bready  = 1'b0;
    axi4l_arvalid = 1'b0;
    axi4l_rready  = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) state_nxt = cmd_write ? ST_WR : ST_RD_ADDR;
      end
      ST_WR: begin
        axi4l_awvalid = !aw_done;
        axi4l_wvalid  = !w_done;
        if (tmo_hit)
          state_nxt = ST_RSP;
        else if ((aw_done || aw_hs) && (w_done || w_hs))
          state_nxt = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        axi4l_bready = 1'b1;
        if (b_hs || tmo_hit) state_nxt = ST_RSP;
      end
      ST_RD_ADDR: begin
        axi4l_arvalid = 1'b1;
        if (tmo_hit)    state_nxt = ST_RSP;
        else if (ar_hs) state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        axi4l_rready = 1'b1;
        if (r_hs || tmo_hit) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= OKAY;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        cnt     <= '0;
      end else if (busy) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      // A real B/R handshake takes priority over a coincident timeout.
      if (b_hs) begin
        rsp_rdata   <= '0;
        rsp_resp    <= axi4l_bresp;
        rsp_timeout <= 1'b0;
      end else if (r_hs) begin
        rsp_rdata   <= axi4l_rdata;
        rsp_resp    <= axi4l_rresp;
        rsp_timeout <= 1'b0;
      end else if (tmo_hit) begin
        rsp_rdata   <= '0;
        rsp_resp    <= SLVERR;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4l_cmd_master.sv
// Self-checking bench for axi4l_cmd_master (TIMEOUT = 16).
// The bench plays both the command source and a word-addressed memory slave
// with per-channel wait counts; expected latency, data and response come
// from closed-form timing rules and a memory array model.
module tb_axi4l_cmd_master;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] axi4l_awaddr, axi4l_wdata, axi4l_araddr, axi4l_rdata;
  logic [2:0]  axi4l_awprot, axi4l_arprot;
  logic        axi4l_awvalid, axi4l_awready, axi4l_wvalid, axi4l_wready;
  logic [3:0]  axi4l_wstrb;
  logic [1:0]  axi4l_bresp, axi4l_rresp;
  logic        axi4l_bvalid, axi4l_bready, axi4l_arvalid, axi4l_arready;
  logic        axi4l_rvalid, axi4l_rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [16];

  axi4l_cmd_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .axi4l_awaddr(axi4l_awaddr), .axi4l_awprot(axi4l_awprot),
    .axi4l_awvalid(axi4l_awvalid), .axi4l_awready(axi4l_awready),
    .axi4l_wdata(axi4l_wdata), .axi4l_wstrb(axi4l_wstrb),
    .axi4l_wvalid(axi4l_wvalid), .axi4l_wready(axi4l_wready),
    .axi4l_bresp(axi4l_bresp), .axi4l_bvalid(axi4l_bvalid), .axi4l_bready(axi4l_bready),
    .axi4l_araddr(axi4l_araddr), .axi4l_arprot(axi4l_arprot),
    .axi4l_arvalid(axi4l_arvalid), .axi4l_arready(axi4l_arready),
    .axi4l_rdata(axi4l_rdata), .axi4l_rresp(axi4l_rresp),
    .axi4l_rvalid(axi4l_rvalid), .axi4l_rready(axi4l_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    axi4l_awready = 1'b0;
    axi4l_wready  = 1'b0;
    axi4l_bvalid  = 1'b0;
    axi4l_bresp   = 2'b00;
    axi4l_arready = 1'b0;
    axi4l_rvalid  = 1'b0;
    axi4l_rdata   = 32'h0;
    axi4l_rresp   = 2'b00;
  endtask

  // Holds reset for one edge, checks every output is cleared, releases it.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
    chk("rst_axi_valids", {axi4l_awvalid, axi4l_wvalid, axi4l_bready,
                           axi4l_arvalid, axi4l_rready}, 0);
    chk("rst_axi_payload", {axi4l_awaddr, axi4l_wdata, axi4l_wstrb,
                            axi4l_awprot, axi4l_arprot}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_cmd_ready", cmd_ready, 1);
  endtask

  // One command with slave wait counts d1 (AW/AR), d2 (W), d3 (B/R),
  // slave response sresp, and rsp_ready held low for `hold` cycles.
  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input int d1, input int d2, input int d3,
                     input logic [1:0] sresp, input int hold, output bit timed_out);
    int h, exp_cyc, rsp_cyc, c, aw_hi, w_hi, ar_hi, b_wait, r_wait, bready_first;
    bit exp_to, chan_ok, busy_ok, hold_ok;
    logic [31:0] exp_rdata, snap_rdata;
    logic [1:0]  exp_resp, snap_resp;
    logic        snap_to;

    // Cycle (after acceptance at cycle 0) of the final B or R handshake.
    h = wr ? (imax(d1, d2) + 2 + d3) : (d1 + 2 + d3);
    exp_to    = (h > TMO);
    exp_cyc   = exp_to ? TMO + 1 : h + 1;
    exp_rdata = (wr || exp_to) ? 32'h0 : mem[addr[5:2]];
    exp_resp  = exp_to ? 2'b10 : sresp;
    timed_out = exp_to;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    c = 1; rsp_cyc = -1; aw_hi = 0; w_hi = 0; ar_hi = 0; b_wait = 0; r_wait = 0;
    bready_first = -1; chan_ok = 1'b1; busy_ok = 1'b1;
    while (rsp_cyc < 0 && c <= 60) begin
      if (rsp_valid) begin
        rsp_cyc = c;
      end else begin
        if (cmd_ready) busy_ok = 1'b0;
        if (axi4l_awprot !== 3'b000 || axi4l_arprot !== 3'b000) chan_ok = 1'b0;
        if (wr && (axi4l_arvalid || axi4l_rready)) chan_ok = 1'b0;
        if (!wr && (axi4l_awvalid || axi4l_wvalid || axi4l_bready)) chan_ok = 1'b0;
        slave_idle();
        if (axi4l_awvalid) begin
          if (axi4l_awaddr !== addr) chan_ok = 1'b0;
          axi4l_awready = (aw_hi == d1);
          aw_hi++;
        end
        if (axi4l_wvalid) begin
          if (axi4l_wdata !== wd || axi4l_wstrb !== st) chan_ok = 1'b0;
          axi4l_wready = (w_hi == d2);
          w_hi++;
        end
        if (axi4l_bready) begin
          if (bready_first < 0) bready_first = c;
          axi4l_bvalid = (b_wait == d3);
          axi4l_bresp  = sresp;
          b_wait++;
        end
        if (axi4l_arvalid) begin
          if (axi4l_araddr !== addr) chan_ok = 1'b0;
          axi4l_arready = (ar_hi == d1);
          ar_hi++;
        end
        if (axi4l_rready) begin
          axi4l_rvalid = (r_wait == d3);
          axi4l_rdata  = mem[addr[5:2]];
          axi4l_rresp  = sresp;
          r_wait++;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    slave_idle();

    chk("rsp_seen", (rsp_cyc >= 0), 1);
    if (rsp_cyc < 0) return;
    chk("rsp_latency", rsp_cyc, exp_cyc);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_resp", rsp_resp, exp_resp);
    chk("rsp_timeout", rsp_timeout, exp_to);
    chk("axi_channel_payload", chan_ok, 1);
    chk("cmd_ready_busy_low", busy_ok, 1);
    chk("axi_quiet_in_rsp", {axi4l_awvalid, axi4l_wvalid, axi4l_bready,
                             axi4l_arvalid, axi4l_rready}, 0);
    if (wr) begin
      chk("awvalid_cycles", aw_hi, imin(d1 + 1, TMO));
      chk("wvalid_cycles", w_hi, imin(d2 + 1, TMO));
      if (!exp_to) chk("bready_first_cycle", bready_first, imax(d1, d2) + 2);
    end else begin
      chk("arvalid_cycles", ar_hi, imin(d1 + 1, TMO));
    end

    snap_rdata = rsp_rdata; snap_resp = rsp_resp; snap_to = rsp_timeout;
    hold_ok = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || cmd_ready || rsp_rdata !== snap_rdata ||
          rsp_resp !== snap_resp || rsp_timeout !== snap_to) hold_ok = 1'b0;
    end
    chk("rsp_hold_stable", hold_ok, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("cmd_ready_after_rsp", cmd_ready, 1);
    chk("rsp_valid_after_rsp", rsp_valid, 0);

    if (wr && !exp_to)
      for (int b = 0; b < 4; b++)
        if (st[b]) mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    bit to;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    slave_idle();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Zero-wait write, then read it back.
    txn(1'b1, 32'h04, 32'h0000_00A5, 4'hF, 0, 0, 0, 2'b00, 0, to);
    txn(1'b0, 32'h04, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, to);
    // Skewed write channels: AW waits 5 cycles, W waits 1.
    txn(1'b1, 32'h08, 32'h1234_5678, 4'hF, 5, 1, 0, 2'b00, 0, to);
    txn(1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, 0, 3, 1, 2'b00, 1, to);
    // Slave error with response backpressure for 10 cycles.
    txn(1'b0, 32'h08, 32'h0, 4'h0, 0, 0, 1, 2'b10, 10, to);
    // DECERR passes through; partial strobe merge then read.
    txn(1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, 2'b11, 2, to);
    txn(1'b0, 32'h08, 32'h0, 4'h0, 2, 0, 0, 2'b01, 0, to);
    // R handshake on the last cycle before abort: real response wins.
    txn(1'b0, 32'h0C, 32'h0, 4'h0, 0, 0, 14, 2'b00, 0, to);
    // One cycle later: timeout in the read-data phase.
    txn(1'b0, 32'h0C, 32'h0, 4'h0, 0, 0, 15, 2'b00, 0, to);
    do_reset();
    // Slave never accepts AR.
    txn(1'b0, 32'h10, 32'h0, 4'h0, 100, 0, 0, 2'b00, 3, to);
    do_reset();

    // Reset in the middle of a stalled write.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20;
    cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    chk("midrst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("midrst_wr_pending", {axi4l_awvalid, axi4l_wvalid}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_axi_low", {axi4l_awvalid, axi4l_wvalid, axi4l_bready,
                           axi4l_arvalid, axi4l_rready}, 0);
    chk("midrst_no_rsp", rsp_valid, 0);
    chk("midrst_cmd_ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cmd_ready_release", cmd_ready, 1);
    chk("midrst_no_rsp_after", rsp_valid, 0);

    // Randomised traffic against the memory model.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [1:0]  r;
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      r = 2'($urandom_range(0, 3));
      txn(1'($urandom_range(0, 1)), a, d, s,
          $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
          r, $urandom_range(0, 3), to);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4l_cmd_master.md
# axi4l_cmd_master

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into one AXI4-Lite read or write transaction and returns the result on a valid/ready response stream. It sits directly upstream of the UART top level and drives its AXI4-Lite slave port. Test sequencers and small control FSMs use it to reach the UART registers without handling the five AXI channels. A timeout counter converts a non-responding slave into an error response.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles from command acceptance to forced abort; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `cmd_wstrb`  in  4  write strobes; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  read data; 0 for writes and timeouts.
- `rsp_resp`  out  2  BRESP/RRESP, or SLVERR on timeout.
- `rsp_timeout`  out  1  response was produced by the timeout.
- `axi4l_awaddr`/`awprot`/`awvalid`/`awready`, `axi4l_wdata`/`wstrb`/`wvalid`/`wready`, `axi4l_bresp`/`bvalid`/`bready`, `axi4l_araddr`/`arprot`/`arvalid`/`arready`, `axi4l_rdata`/`rresp`/`rvalid`/`rready`: the standard AXI4-Lite master side.
  - Widths: address and data 32, `wstrb` 4, `prot` 3, `resp` 2.
  - `awprot` and `arprot` are tied to 3'b000.

## Operation
- States: IDLE, WR (AW and W pending), WR_RESP, RD_ADDR, RD_DATA, RSP.
- **IDLE:** `cmd_ready`=1.
  - On `cmd_valid`, capture `cmd_*` into registers and clear the timeout counter.
  - A write goes to WR; a read goes to RD_ADDR.
- **WR:**
  - `awvalid` and `wvalid` both assert on entry.
  - Each drops independently on its own handshake; AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- **WR_RESP:** `bready`=1. On `bvalid`, capture `bresp` and go to RSP.
- **RD_ADDR:** `arvalid`=1. On `arready`, go to RD_DATA.
- **RD_DATA:** `rready`=1. On `rvalid`, capture `rdata` and `rresp`, then go to RSP.
- **RSP:**
  - `rsp_valid`=1; `rsp_*` stay stable until `rsp_ready`.
  - Then return to IDLE, with `cmd_ready` high on the following cycle.
- AXI address, data and strobe outputs come straight from the captured registers and stay stable while their VALID is high.
- **Timeout:**
  - The counter runs in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches `TIMEOUT`, all AXI valids and readies drop, and the block goes to RSP with `rsp_resp`=2'b10, `rsp_timeout`=1 and `rsp_rdata`=0.
  - This breaks the AXI rules by design; the slave must be reset afterwards.
- `rsp_resp` passes the slave's value through unchanged, including DECERR.

## Timing
- **Reset:**
  - State goes to IDLE; the timeout counter clears.
  - All outputs are 0, including `cmd_ready`, which is held at 0 while `rst` is high.
  - `rsp_*` registers clear to 0.
- **Reset during a transaction:** abandon it immediately with no response. AXI valids and readies are low on the cycle after `rst` is sampled.
- **Write latency with zero-wait slave:** command accepted at cycle 0 → AW and W handshake at cycle 1 → B handshake at cycle 2 → `rsp_valid` at cycle 3.
- **Read latency with zero-wait slave:** AR handshake at cycle 1 → R handshake at cycle 2 → `rsp_valid` at cycle 3.
- `cmd_ready` is 0 from the cycle after acceptance until the cycle after the response handshake. At most one transaction is outstanding.
- **`rsp_ready` held low:** the block stays in RSP indefinitely and accepts no new command.
- **Response vs timeout in the same cycle:** the real response wins and `rsp_timeout`=0.
- **Counter width:** `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.

## Structure
- Shared package `axi4l_pkg` holds:
  - response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the `axi4l_cmd_state_t` enum for the six states.
- No sub-modules: the FSM, capture registers and timeout counter are all inline.

## Test plan
- **Zero-wait write:** write 0x000000A5 with strobe 4'hF to address 0x04 on a slave that is always ready → one AW/W handshake, then `rsp_valid` at cycle 3 with `rsp_resp`=2'b00 and `rsp_timeout`=0.
- **Read after write:** read from 0x04 after the write above → `araddr`=0x04, `rsp_rdata`=0x000000A5, `rsp_resp`=2'b00, `rsp_valid` at cycle 3.
- **Skewed write channels:** slave holds `awready` for 5 cycles and `wready` for 1 cycle → `wvalid` drops after 1 cycle, `awvalid` after 5, and `bready` rises only after both.
- **Response backpressure plus slave error:** slave returns `rresp`=2'b10 while `rsp_ready` is held low for 10 cycles → `rsp_*` are stable throughout, `cmd_ready` stays 0, and `rsp_resp`=2'b10.
- **Timeout:** `TIMEOUT`=16 and the slave never asserts `arready` → `arvalid` drops 16 cycles after acceptance, then `rsp_timeout`=1, `rsp_resp`=2'b10, `rsp_rdata`=0.
- **Reset mid-write:** assert `rst` during WR → no `rsp_valid`, all AXI valids 0 on the next cycle, and `cmd_ready`=1 on the first cycle after `rst` is released.
